// File: rtl/dr32e_if_id_reg.sv
// IF/ID pipeline register for dr32e: one ID entry plus a one-entry skid buffer,
// so that fetch_ready_o comes straight from a flop.
module dr32e_if_id_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_is_compressed_i,
  input  logic        fetch_illegal_c_i,
  input  logic        fetch_err_i,
  input  logic        id_in_ready_i,
  input  logic        flush_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] instr_rdata_alu_id_o,
  output logic [31:0] pc_id_o,
  output logic        instr_is_compressed_id_o,
  output logic        illegal_c_insn_id_o,
  output logic        instr_fetch_err_id_o,
  output logic        instr_first_cycle_id_o,
  output logic [3:0]  instr_stall_cnt_o
);

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        comp;
    logic        illc;
    logic        err;
  } payload_t;

  payload_t   beat;
  payload_t   id_q, id_d;
  payload_t   skid_q, skid_d;
  logic       id_valid_q, id_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       first_q, first_d;
  logic       ready_q;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_alu_q;
  logic       accept;
  logic       advance;
  logic       load;

  always_comb begin
    // illegal_c is masked on capture so a fetch error always wins
    beat.rdata = fetch_rdata_i;
    beat.pc    = fetch_pc_i;
    beat.comp  = fetch_is_compressed_i;
    beat.illc  = fetch_illegal_c_i & ~fetch_err_i;
    beat.err   = fetch_err_i;
  end

  assign accept  = fetch_valid_i & ready_q & ~flush_i;
  assign advance = id_in_ready_i | ~id_valid_q;

  always_comb begin
    id_d         = id_q;
    skid_d       = skid_q;
    id_valid_d   = id_valid_q;
    skid_valid_d = skid_valid_q;
    first_d      = first_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    if (flush_i) begin
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      first_d      = 1'b0;
      cnt_d        = 4'd0;
    end else if (advance) begin
      if (skid_valid_q) begin
        load         = 1'b1;
        id_d         = skid_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = beat;
        end
      end else if (accept) begin
        load = 1'b1;
        id_d = beat;
      end
      id_valid_d = load;
      first_d    = load;
      cnt_d      = 4'd0;
    end else begin
      first_d = 1'b0;
      if (cnt_q != 4'hf) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (accept) begin
        skid_d       = beat;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q         <= '0;
      skid_q       <= '0;
      id_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      first_q      <= 1'b0;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
    end else begin
      id_q         <= id_d;
      skid_q       <= skid_d;
      id_valid_q   <= id_valid_d;
      skid_valid_q <= skid_valid_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  // Separate copy of the instruction word to split decoder and ALU fan-out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_alu_q <= '0;
    end else if (load) begin
      rdata_alu_q <= skid_valid_q ? skid_q.rdata : fetch_rdata_i;
    end
  end

  assign fetch_ready_o            = ready_q;
  assign instr_valid_id_o         = id_valid_q;
  assign instr_rdata_id_o         = id_q.rdata;
  assign instr_rdata_alu_id_o     = rdata_alu_q;
  assign pc_id_o                  = id_q.pc;
  assign instr_is_compressed_id_o = id_q.comp;
  assign illegal_c_insn_id_o      = id_q.illc;
  assign instr_fetch_err_id_o     = id_q.err;
  assign instr_first_cycle_id_o   = id_valid_q & first_q;
  assign instr_stall_cnt_o        = id_valid_q ? cnt_q : 4'd0;

endmodule

// File: tb/tb_dr32e_if_id_reg.sv
// Bench for dr32e_if_id_reg: fixed vector table, corner sequences and random
// traffic checked against a queue-based model of the held instructions.
module tb_dr32e_if_id_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fvalid;
  logic        fready;
  logic [31:0] frdata;
  logic [31:0] fpc;
  logic        fcomp;
  logic        fillc;
  logic        ferr;
  logic        id_ready;
  logic        flush;
  logic        valid;
  logic [31:0] rdata;
  logic [31:0] rdata_alu;
  logic [31:0] pc;
  logic        comp;
  logic        illc;
  logic        err;
  logic        first;
  logic [3:0]  cnt;

  always #5 clk = ~clk;

  dr32e_if_id_reg dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .fetch_valid_i            (fvalid),
    .fetch_ready_o            (fready),
    .fetch_rdata_i            (frdata),
    .fetch_pc_i               (fpc),
    .fetch_is_compressed_i    (fcomp),
    .fetch_illegal_c_i        (fillc),
    .fetch_err_i              (ferr),
    .id_in_ready_i            (id_ready),
    .flush_i                  (flush),
    .instr_valid_id_o         (valid),
    .instr_rdata_id_o         (rdata),
    .instr_rdata_alu_id_o     (rdata_alu),
    .pc_id_o                  (pc),
    .instr_is_compressed_id_o (comp),
    .illegal_c_insn_id_o      (illc),
    .instr_fetch_err_id_o     (err),
    .instr_first_cycle_id_o   (first),
    .instr_stall_cnt_o        (cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        comp;
    logic        illc;
    logic        err;
  } pl_t;

  // Model: held[0] is the ID instruction, held[1] the skid one
  pl_t held[$];
  pl_t last;
  bit  m_first;
  int  m_cnt;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    held.delete();
    last    = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    m_first = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    bit  adv;
    bit  acc;
    pl_t p;
    if (flush) begin
      held.delete();
      m_first = 1'b0;
      m_cnt   = 0;
    end else begin
      adv = id_ready || (held.size() == 0);
      acc = fvalid && (held.size() < 2);
      if (adv && held.size() > 0) void'(held.pop_front());
      if (acc) begin
        p = '{frdata, fpc, fcomp, fillc, ferr};
        held.push_back(p);
      end
      if (adv) begin
        m_cnt   = 0;
        m_first = (held.size() > 0);
        if (held.size() > 0) last = held[0];
      end else begin
        m_first = 1'b0;
        if (m_cnt < 15) m_cnt++;
      end
    end
  endtask

  task automatic check_model();
    bit v;
    v = (held.size() > 0);
    chk("m_valid", valid, v);
    chk("m_ready", fready, held.size() < 2);
    chk("m_first", first, v && m_first);
    chk("m_cnt", cnt, v ? m_cnt : 0);
    chk("m_rdata", rdata, last.rdata);
    chk("m_rdata_alu", rdata_alu, last.rdata);
    chk("m_pc", pc, last.pc);
    chk("m_comp", comp, last.comp);
    chk("m_illc", illc, last.illc & ~last.err);
    chk("m_err", err, last.err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(bit v, logic [31:0] p, bit rdy, bit fl,
                       bit c = 1'b0, bit il = 1'b0, bit e = 1'b0);
    fvalid   = v;
    fpc      = p;
    frdata   = $urandom;
    id_ready = rdy;
    flush    = fl;
    fcomp    = c;
    fillc    = il;
    ferr     = e;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, fready, 1);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_first"}, first, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_alu"}, rdata_alu, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_flags"}, {comp, illc, err}, 0);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_first;
    int          e_cnt;
    bit          e_ready;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // streaming, empty, then a 4-edge stall with skid capture and release
    tbl[0]  = '{1'b1, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 0, 1'b1};
    tbl[1]  = '{1'b1, 32'h4,  1'b1, 1'b1, 32'h4,  1'b1, 0, 1'b1};
    tbl[2]  = '{1'b1, 32'h8,  1'b1, 1'b1, 32'h8,  1'b1, 0, 1'b1};
    tbl[3]  = '{1'b1, 32'hC,  1'b1, 1'b1, 32'hC,  1'b1, 0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b1};
    tbl[5]  = '{1'b1, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 0, 1'b1};
    tbl[6]  = '{1'b1, 32'h4,  1'b0, 1'b1, 32'h0,  1'b0, 1, 1'b0};
    tbl[7]  = '{1'b1, 32'h8,  1'b0, 1'b1, 32'h0,  1'b0, 2, 1'b0};
    tbl[8]  = '{1'b1, 32'h8,  1'b0, 1'b1, 32'h0,  1'b0, 3, 1'b0};
    tbl[9]  = '{1'b1, 32'h8,  1'b0, 1'b1, 32'h0,  1'b0, 4, 1'b0};
    tbl[10] = '{1'b1, 32'h8,  1'b1, 1'b1, 32'h4,  1'b1, 0, 1'b1};
    tbl[11] = '{1'b1, 32'h8,  1'b1, 1'b1, 32'h8,  1'b1, 0, 1'b1};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].rdy, 1'b0);
      tick();
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_first", i), first, tbl[i].e_first);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ready", i), fready, tbl[i].e_ready);
    end

    // saturation of the stall counter
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat_cnt%0d", i), cnt, (i < 15) ? i : 15);
    end
    drive(1'b1, 32'h44, 1'b1, 1'b0);
    tick();
    chk("sat_next_pc", pc, 32'h44);
    chk("sat_next_cnt", cnt, 0);
    chk("sat_next_first", first, 1);

    // flush with ID and skid full plus an incoming beat
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    tick();
    chk("fl_pre_ready", fready, 0);
    chk("fl_pre_pc", pc, 32'h10);
    drive(1'b1, 32'h18, 1'b1, 1'b1);
    tick();
    chk("fl_valid", valid, 0);
    chk("fl_ready", fready, 1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_18", valid, 0);
    end

    // flag handling
    drive(1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flag_err", err, 1);
    chk("flag_err_illc", illc, 0);
    drive(1'b1, 32'h52, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("flag_illc", illc, 1);
    chk("flag_comp", comp, 1);
    chk("flag_noerr", err, 0);

    // async reset in the middle of a stall
    drive(1'b1, 32'h60, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h64, 1'b0, 1'b0);
    tick();
    tick();
    chk("ar_pre_cnt", cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      tick();
      chk($sformatf("ar_stream_pc%0d", i), pc, 32'(i * 4));
      chk($sformatf("ar_stream_first%0d", i), first, 1);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
